// File: rtl/tsu_sched.sv
// Scheduled-mark generator: rational phase accumulator plus a small FIFO of target phases.
// Optional macro TSU_SCHED_LATE_FIRE_EN: a late head still produces o_mark with zero residual.
module tsu_sched #(
  parameter int RAT_PREC_BITS   = 32,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RAT_PREC_BITS-1:0]   i_num,
  input  logic                       i_time_load,
  input  logic [RAT_PREC_BITS-1:0]   i_time_val,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [RAT_PREC_BITS-1:0]   i_req_phase,
  output logic                       o_mark,
  output logic [RAT_PREC_BITS-1:0]   o_mark_phase,
  output logic                       o_late,
  output logic [RAT_PREC_BITS-1:0]   o_phase,
  output logic [FIFO_DEPTH_BITS:0]   o_pending
);

  localparam int N     = RAT_PREC_BITS;
  localparam int D     = FIFO_DEPTH_BITS;
  localparam int DEPTH = 1 << D;

  localparam logic [N-1:0] PHASE_ZERO = {N{1'b0}};
  localparam logic [D:0]   PTR_ZERO   = {(D+1){1'b0}};
  localparam logic [D:0]   PTR_ONE    = {{D{1'b0}}, 1'b1};

`ifdef TSU_SCHED_LATE_FIRE_EN
  localparam logic LATE_FIRE = 1'b1;
`else
  localparam logic LATE_FIRE = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [N-1:0]   now_r;
  logic [N-1:0]   mem_r [DEPTH];
  logic [D:0]     wr_ptr_r;
  logic [D:0]     rd_ptr_r;
  logic [D:0]     pending_r;
  logic           mark_r;
  logic           late_r;
  logic [N-1:0]   mark_phase_r;

  logic           full_s;
  logic           empty_s;
  logic           push_s;
  logic           pop_s;
  logic           eval_s;
  logic           fire_s;
  logic           late_s;
  logic [N-1:0]   head_s;
  logic [N-1:0]   diff_s;
  logic [D:0]     pending_nxt_s;
  logic           mark_nxt_s;
  logic [N-1:0]   mark_phase_nxt_s;

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign full_s      = (wr_ptr_r[D] != rd_ptr_r[D]) && (wr_ptr_r[D-1:0] == rd_ptr_r[D-1:0]);
  assign o_req_ready = ~full_s & ~rst;
  assign push_s      = i_req_valid & o_req_ready;

  assign o_mark       = mark_r;
  assign o_late       = late_r;
  assign o_mark_phase = mark_phase_r;
  assign o_phase      = now_r;
  assign o_pending    = pending_r;

  // Head evaluation against the pre-load accumulator value.
  always_comb begin
    head_s = mem_r[rd_ptr_r[D-1:0]];
    diff_s = head_s - now_r;
    eval_s = (state_r != ST_EMPTY) && !empty_s;
    fire_s = eval_s && (diff_s < i_num);
    late_s = eval_s && !fire_s && diff_s[N-1];
    pop_s  = fire_s | late_s;
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    pending_nxt_s = pending_r;
    case ({push_s, pop_s})
      2'b10:   pending_nxt_s = pending_r + PTR_ONE;
      2'b01:   pending_nxt_s = pending_r - PTR_ONE;
      default: pending_nxt_s = pending_r;
    endcase
  end

  // Mark output selection; a late head only marks when late firing is built in.
  always_comb begin
    mark_nxt_s       = 1'b0;
    mark_phase_nxt_s = mark_phase_r;
    if (fire_s) begin
      mark_nxt_s       = 1'b1;
      mark_phase_nxt_s = diff_s;
    end else if (late_s && LATE_FIRE) begin
      mark_nxt_s       = 1'b1;
      mark_phase_nxt_s = PHASE_ZERO;
    end else begin
      mark_nxt_s       = 1'b0;
      mark_phase_nxt_s = mark_phase_r;
    end
  end

  // Next-state logic; FIRED lasts one cycle while the next head is already evaluated.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (push_s) begin
          state_s = ST_ARMED;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_ARMED: begin
        if (pop_s) begin
          state_s = ST_FIRED;
        end else begin
          state_s = ST_ARMED;
        end
      end
      ST_FIRED: begin
        if (pending_nxt_s != PTR_ZERO) begin
          state_s = ST_ARMED;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // State, accumulator, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      now_r        <= PHASE_ZERO;
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      pending_r    <= PTR_ZERO;
      mark_r       <= 1'b0;
      late_r       <= 1'b0;
      mark_phase_r <= PHASE_ZERO;
    end else begin
      state_r      <= state_s;
      now_r        <= i_time_load ? i_time_val : (now_r + i_num);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      pending_r    <= pending_nxt_s;
      mark_r       <= mark_nxt_s;
      late_r       <= late_s;
      mark_phase_r <= mark_phase_nxt_s;
    end
  end

  // Request storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[D-1:0]] <= i_req_phase;
    end
  end

endmodule

// File: tb/tb_tsu_sched.sv
// Scoreboard bench for tsu_sched: expected marks are queued at stimulus time, a monitor pops them.
module tb_tsu_sched;
  localparam int N = 32;
  localparam int D = 2;

`ifdef TSU_SCHED_LATE_FIRE_EN
  localparam logic LM = 1'b1;
  localparam logic [N-1:0] LATE_PH = 32'd0;
`else
  localparam logic LM = 1'b0;
  localparam logic [N-1:0] LATE_PH = 32'd5;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] i_num = 32'd8;
  logic         i_time_load = 1'b0;
  logic [N-1:0] i_time_val = 32'd0;
  logic         i_req_valid = 1'b0;
  logic         o_req_ready;
  logic [N-1:0] i_req_phase = 32'd0;
  logic         o_mark;
  logic [N-1:0] o_mark_phase;
  logic         o_late;
  logic [N-1:0] o_phase;
  logic [D:0]   o_pending;

  tsu_sched #(.RAT_PREC_BITS(N), .FIFO_DEPTH_BITS(D)) dut (
    .clk(clk), .rst(rst), .i_num(i_num), .i_time_load(i_time_load), .i_time_val(i_time_val),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_phase(i_req_phase),
    .o_mark(o_mark), .o_mark_phase(o_mark_phase), .o_late(o_late), .o_phase(o_phase),
    .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic         mark;
    logic         late;
    logic [N-1:0] ph;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   base = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc - base);
    end
  endtask

  task automatic expect_ev(input int c, input logic m, input logic l, input logic [N-1:0] ph);
    exp_t e;
    e.cyc = base + c; e.mark = m; e.late = l; e.ph = ph;
    sb.push_back(e);
  endtask

  // Monitor: every pulse on o_mark/o_late must match the head of the scoreboard.
  always @(negedge clk) begin
    if (o_mark === 1'b1 || o_late === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: mark=%0b late=%0b phase=%0d at cycle %0d, none expected",
                 o_mark, o_late, o_mark_phase, cyc - base);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_cycle", cyc - base, e.cyc - base);
        chk("out_mark", {31'd0, o_mark}, {31'd0, e.mark});
        chk("out_late", {31'd0, o_late}, {31'd0, e.late});
        chk("out_phase", o_mark_phase, e.ph);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_req_valid = 1'b0; i_time_load = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, o_req_ready}, 32'd0);
    chk("rst_pending", {29'd0, o_pending}, 32'd0);
    chk("rst_mark", {31'd0, o_mark}, 32'd0);
    chk("rst_late", {31'd0, o_late}, 32'd0);
    chk("rst_phase", o_phase, 32'd0);
    chk("rst_mark_phase", o_mark_phase, 32'd0);
    rst = 1'b0;
    base = cyc;
    #1;
    chk("post_rst_ready", {31'd0, o_req_ready}, 32'd1);
  endtask

  task automatic push(input logic [N-1:0] p);
    i_req_valid = 1'b1; i_req_phase = p;
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic load(input logic [N-1:0] v);
    i_time_load = 1'b1; i_time_val = v;
    @(negedge clk);
    i_time_load = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc - base < c) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs still outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int t;
    // On-time fire at now=40
    do_reset();
    expect_ev(6, 1'b1, 1'b0, 32'd0);
    push(32'd40);
    chk("ontime_phase_c1", o_phase, 32'd8);
    chk("ontime_pending_c1", {29'd0, o_pending}, 32'd1);
    drain(20);
    chk("ontime_pending_end", {29'd0, o_pending}, 32'd0);

    // Residuals, back-to-back fires on consecutive cycles
    do_reset();
    expect_ev(6, 1'b1, 1'b0, 32'd5);
    expect_ev(7, 1'b1, 1'b0, 32'd7);
    push(32'd45);
    push(32'd55);
    drain(20);
    chk("b2b_pending_end", {29'd0, o_pending}, 32'd0);

    // Full FIFO: fifth push refused, ready returns after the first fire
    do_reset();
    expect_ev(13, 1'b1, 1'b0, 32'd4);
    expect_ev(26, 1'b1, 1'b0, 32'd0);
    expect_ev(38, 1'b1, 1'b0, 32'd4);
    expect_ev(51, 1'b1, 1'b0, 32'd0);
    push(32'd100);
    push(32'd200);
    push(32'd300);
    push(32'd400);
    chk("full_ready", {31'd0, o_req_ready}, 32'd0);
    chk("full_pending", {29'd0, o_pending}, 32'd4);
    push(32'd500);
    chk("full_pending_after_5th", {29'd0, o_pending}, 32'd4);
    wait_until(12);
    chk("full_ready_c12", {31'd0, o_req_ready}, 32'd0);
    wait_until(13);
    chk("full_ready_c13", {31'd0, o_req_ready}, 32'd1);
    chk("full_pending_c13", {29'd0, o_pending}, 32'd3);
    drain(60);
    repeat (20) @(negedge clk);
    chk("full_pending_end", {29'd0, o_pending}, 32'd0);

    // Late: residual 5 first, then load 80 and push a target already behind
    do_reset();
    expect_ev(6, 1'b1, 1'b0, 32'd5);
    push(32'd45);
    drain(20);
    t = cyc - base;
    expect_ev(t + 3, LM, 1'b1, LATE_PH);
    load(32'd80);
    chk("late_phase_loaded", o_phase, 32'd80);
    push(32'd8);
    drain(10);
    chk("late_pending_end", {29'd0, o_pending}, 32'd0);

    // Wrap: fires at now=0 with residual 4 and no late report
    do_reset();
    expect_ev(4, 1'b1, 1'b0, 32'd4);
    load(32'hFFFF_FFF0);
    push(32'd4);
    chk("wrap_phase_c2", o_phase, 32'hFFFF_FFF8);
    drain(20);

    // Reset mid-operation flushes pending entries
    do_reset();
    push(32'd100);
    push(32'd200);
    push(32'd300);
    chk("mid_pending_before", {29'd0, o_pending}, 32'd3);
    do_reset();
    expect_ev(3, 1'b1, 1'b0, 32'd0);
    push(32'd16);
    drain(20);
    repeat (40) @(negedge clk);
    chk("mid_pending_end", {29'd0, o_pending}, 32'd0);
    chk("sb_empty_end", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
